// File: rtl/fp_add_pipe_if.sv
// Operand/result handshake bundle for fp_add_pipe.
// master = producer/consumer side, slave = the adder.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/fp_add_pipe.sv
// Pipelined FP add/sub: align, add, normalise, round/pack.
// Subnormals flush to zero; RNE rounding; one op per cycle.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          reset,
  fp_add_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int FW = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef struct packed {
    logic             v;
    logic             spec;
    logic [W-1:0]     spec_y;
    logic             inv;
    logic             zsign;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    ml;
    logic [SW-1:0]    ms;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic             spec;
    logic [W-1:0]     spec_y;
    logic             inv;
    logic             zsign;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
  } s2_t;

  typedef struct packed {
    logic           v;
    logic           spec;
    logic [W-1:0]   spec_y;
    logic           inv;
    logic           zsign;
    logic           sign;
    logic           zero;
    logic           uf;
    logic [EXP_W:0] e;
    logic [SW-1:0]  m;
  } s3_t;

  s1_t s1, s1_n;
  s2_t s2, s2_n;
  s3_t s3, s3_n;

  logic         ov_q;
  logic [W-1:0] y_q;
  logic [3:0]   f_q;
  logic         adv;

  assign adv           = !ov_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = ov_q;
  assign bus.y         = y_q;
  assign bus.flags     = f_q;

  function automatic int lzc(input logic [SW-1:0] v);
    int n;
    n = SW;
    for (int i = 0; i < SW; i++)
      if (v[i]) n = SW - 1 - i;
    return n;
  endfunction

  logic             sa, sb, sl, ss;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, infa, infb, nana, nanb;
  logic [MAN_W:0]   ma, mb, mlg, msm;
  logic [FW-1:0]    ka, kb;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    sm;

  always_comb begin
    s1_n = '0;
    sa   = bus.a[W-1];
    sb   = bus.b[W-1] ^ bus.op;
    ea   = bus.a[W-2:MAN_W];
    eb   = bus.b[W-2:MAN_W];
    fa   = bus.a[MAN_W-1:0];
    fb   = bus.b[MAN_W-1:0];
    za   = ea == '0;
    zb   = eb == '0;
    infa = (ea == EMAX) && (fa == '0);
    infb = (eb == EMAX) && (fb == '0);
    nana = (ea == EMAX) && (fa != '0);
    nanb = (eb == EMAX) && (fb != '0);
    ma   = za ? '0 : {1'b1, fa};
    mb   = zb ? '0 : {1'b1, fb};
    ka   = za ? '0 : bus.a[W-2:0];
    kb   = zb ? '0 : bus.b[W-2:0];
    if (kb > ka) begin
      sl = sb; el = eb; mlg = mb;
      ss = sa; es = ea; msm = ma;
    end else begin
      sl = sa; el = ea; mlg = ma;
      ss = sb; es = eb; msm = mb;
    end
    d    = el - es;
    wide = {msm, {(SW+3){1'b0}}} >> d;
    // far-shifted operand survives only as sticky
    if (int'(d) >= SW - 1)
      sm = {{(SW-1){1'b0}}, |msm};
    else
      sm = wide[2*SW-1:SW]
         | {{(SW-1){1'b0}}, |wide[SW-1:0]};
    s1_n.v     = bus.in_valid;
    s1_n.inv   = nana || nanb
              || (infa && infb && (sa != sb));
    s1_n.spec  = nana || nanb || infa || infb;
    if (s1_n.inv)
      s1_n.spec_y = {1'b0, EMAX, 1'b1,
                     {(MAN_W-1){1'b0}}};
    else if (infa)
      s1_n.spec_y = {sa, EMAX, {MAN_W{1'b0}}};
    else
      s1_n.spec_y = {sb, EMAX, {MAN_W{1'b0}}};
    s1_n.zsign = sa && sb;
    s1_n.sign  = sl;
    s1_n.sub   = sl ^ ss;
    s1_n.exp   = el;
    s1_n.ml    = {mlg, 3'b000};
    s1_n.ms    = sm;
  end

  always_comb begin
    s2_n        = '0;
    s2_n.v      = s1.v;
    s2_n.spec   = s1.spec;
    s2_n.spec_y = s1.spec_y;
    s2_n.inv    = s1.inv;
    s2_n.zsign  = s1.zsign;
    s2_n.sign   = s1.sign;
    s2_n.exp    = s1.exp;
    if (s1.sub)
      s2_n.sum = {1'b0, s1.ml} - {1'b0, s1.ms};
    else
      s2_n.sum = {1'b0, s1.ml} + {1'b0, s1.ms};
  end

  int            lz, en;
  logic [SW-1:0] mn;

  always_comb begin
    s3_n = '0;
    lz   = lzc(s2.sum[SW-1:0]);
    if (s2.sum[SW]) begin
      mn = {s2.sum[SW:2], |s2.sum[1:0]};
      en = int'(s2.exp) + 1;
    end else begin
      mn = s2.sum[SW-1:0] << lz;
      en = int'(s2.exp) - lz;
    end
    s3_n.v      = s2.v;
    s3_n.spec   = s2.spec;
    s3_n.spec_y = s2.spec_y;
    s3_n.inv    = s2.inv;
    s3_n.zsign  = s2.zsign;
    s3_n.sign   = s2.sign;
    s3_n.zero   = s2.sum == '0;
    s3_n.uf     = en <= 0;
    s3_n.e      = (en <= 0) ? '0 : en[EXP_W:0];
    s3_n.m      = mn;
  end

  logic             inc, inx, ovf;
  logic [MAN_W+1:0] mant;
  logic [EXP_W:0]   er;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     y_n;
  logic [3:0]       f_n;

  always_comb begin
    inc  = s3.m[2] && (s3.m[1] || s3.m[0] || s3.m[3]);
    inx  = s3.m[2] || s3.m[1] || s3.m[0];
    mant = {1'b0, s3.m[SW-1:3]}
         + {{(MAN_W+1){1'b0}}, inc};
    er   = s3.e + {{EXP_W{1'b0}}, mant[MAN_W+1]};
    frac = mant[MAN_W+1] ? mant[MAN_W:1]
                         : mant[MAN_W-1:0];
    ovf  = er >= {1'b0, EMAX};
    y_n  = '0;
    f_n  = '0;
    if (s3.spec) begin
      y_n = s3.spec_y;
      f_n = {s3.inv, 3'b000};
    end else if (s3.zero) begin
      y_n = {s3.zsign, {FW{1'b0}}};
    end else if (s3.uf) begin
      y_n = {s3.sign, {FW{1'b0}}};
      f_n = 4'b0011;
    end else if (ovf) begin
      y_n = {s3.sign, EMAX, {MAN_W{1'b0}}};
      f_n = 4'b0101;
    end else begin
      y_n = {s3.sign, er[EXP_W-1:0], frac};
      f_n = {3'b000, inx};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      ov_q <= 1'b0;
      y_q  <= '0;
      f_q  <= '0;
    end else if (adv) begin
      s1   <= s1_n;
      s2   <= s2_n;
      s3   <= s3_n;
      ov_q <= s3.v;
      y_q  <= y_n;
      f_q  <= f_n;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Vector table + scoreboard bench for fp_add_pipe.
// Covers binary32 and binary16 instances.
module tb_fp_add_pipe;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int popped = 0;
  int seen   = 0;
  bit stalled;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    bit          h;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  exp_t q32[$];
  exp_t q16[$];
  bit          held [2];
  logic [31:0] hy [2];
  logic [3:0]  hf [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fp_add_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32.slave)
  );
  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );

  function automatic vec_t mk(bit h, logic op,
    logic [31:0] a, logic [31:0] b,
    logic [31:0] y, logic [3:0] f);
    vec_t v;
    v.h = h; v.op = op; v.a = a; v.b = b;
    v.y = y; v.f = f;
    return v;
  endfunction

  task automatic chk(input string n,
    input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic mon_step(input bit h, input logic v,
    input logic r, input logic [31:0] y,
    input logic [3:0] f);
    exp_t e;
    if (v) seen++;
    if (held[h] && v) begin
      tests++;
      if (y !== hy[h] || f !== hf[h]) begin
        fails++;
        $display("FAIL hold%0d y=%h f=%h want y=%h f=%h",
                 h, y, f, hy[h], hf[h]);
      end
    end
    held[h] = v && !r;
    hy[h]   = y;
    hf[h]   = f;
    if (v && r) begin
      tests++;
      if ((h ? q16.size() : q32.size()) == 0) begin
        fails++;
        $display("FAIL spurious%0d y=%h f=%h want none",
                 h, y, f);
      end else begin
        e = h ? q16.pop_front() : q32.pop_front();
        popped++;
        if (y !== e.y || f !== e.f
            || (e.lat && cyc - e.cyc != 4)) begin
          fails++;
          $display("FAIL result%0d y=%h f=%h lat=%0d want y=%h f=%h lat=4",
                   h, y, f, cyc - e.cyc, e.y, e.f);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon_step(1'b0, bus32.out_valid, bus32.out_ready,
             bus32.y, bus32.flags);
  end

  always @(negedge clk) begin
    #2;
    mon_step(1'b1, bus16.out_valid, bus16.out_ready,
             {16'h0000, bus16.y}, bus16.flags);
  end

  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    int   n;
    @(negedge clk);
    if (v.h) begin
      bus32.in_valid = 1'b0;
      bus16.in_valid = 1'b1;
      bus16.op = v.op;
      bus16.a  = v.a[15:0];
      bus16.b  = v.b[15:0];
    end else begin
      bus16.in_valid = 1'b0;
      bus32.in_valid = 1'b1;
      bus32.op = v.op;
      bus32.a  = v.a;
      bus32.b  = v.b;
    end
    #1;
    n = 0;
    while (!(v.h ? bus16.in_ready : bus32.in_ready)
           && n < 50) begin
      stalled = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout in_ready=0 want 1");
    end else begin
      e.y = v.y; e.f = v.f; e.cyc = cyc; e.lat = lat;
      if (v.h) q16.push_back(e);
      else     q32.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q16.size() != 0)
           && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout left=%0d want 0",
               q32.size() + q16.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    vec_t bp[$];
    int   p0, s0;

    tv.push_back(mk(0,0,32'h3F800000,32'h3F800000,32'h40000000,4'h0));
    tv.push_back(mk(0,0,32'h3F000000,32'h3E800000,32'h3F400000,4'h0));
    tv.push_back(mk(0,0,32'h3F800000,32'hBF000000,32'h3F000000,4'h0));
    tv.push_back(mk(0,1,32'h3F800000,32'h3F800000,32'h00000000,4'h0));
    tv.push_back(mk(0,1,32'h41200000,32'hC1200000,32'h41A00000,4'h0));
    tv.push_back(mk(0,0,32'h3F800000,32'h33800000,32'h3F800000,4'h1));
    tv.push_back(mk(0,0,32'h3F800000,32'h33800001,32'h3F800001,4'h1));
    tv.push_back(mk(0,0,32'h7F7FFFFF,32'h7F7FFFFF,32'h7F800000,4'h5));
    tv.push_back(mk(0,0,32'h7F800000,32'hFF800000,32'h7FC00000,4'h8));
    tv.push_back(mk(0,0,32'h00000001,32'h3F800000,32'h3F800000,4'h0));
    tv.push_back(mk(0,0,32'h80000000,32'h80000000,32'h80000000,4'h0));
    tv.push_back(mk(0,1,32'h7F800000,32'h7F800000,32'h7FC00000,4'h8));
    tv.push_back(mk(0,0,32'hFF800000,32'hFF800000,32'hFF800000,4'h0));
    tv.push_back(mk(0,0,32'h3F800000,32'h7F800000,32'h7F800000,4'h0));
    tv.push_back(mk(0,0,32'h7FC00001,32'h3F800000,32'h7FC00000,4'h8));
    tv.push_back(mk(0,1,32'h00800000,32'h00800001,32'h80000000,4'h3));
    tv.push_back(mk(0,0,32'h3FFFFFFF,32'h33800000,32'h40000000,4'h1));
    tv.push_back(mk(0,0,32'h3F800000,32'h30800000,32'h3F800000,4'h1));
    tv.push_back(mk(0,0,32'h4B800000,32'h3F800000,32'h4B800000,4'h1));
    tv.push_back(mk(0,0,32'h3FC00000,32'h3FC00000,32'h40400000,4'h0));
    tv.push_back(mk(0,1,32'h40000000,32'h3F800000,32'h3F800000,4'h0));
    tv.push_back(mk(1,0,32'h3C00,32'h3C00,32'h4000,4'h0));
    tv.push_back(mk(1,0,32'h3800,32'h3400,32'h3A00,4'h0));
    tv.push_back(mk(1,0,32'h3C00,32'hB800,32'h3800,4'h0));
    tv.push_back(mk(1,1,32'h3C00,32'h3C00,32'h0000,4'h0));
    tv.push_back(mk(1,0,32'h7BFF,32'h7BFF,32'h7C00,4'h5));
    tv.push_back(mk(1,0,32'h7C00,32'hFC00,32'h7E00,4'h8));
    tv.push_back(mk(1,0,32'h3C00,32'h1000,32'h3C00,4'h1));

    for (int i = 0; i < 6; i++)
      bp.push_back(mk(0, 0, 32'h3F800000 + i * 32'h0,
                      32'h3F800000, 32'h0, 4'h0));
    bp[0].a = 32'h3F800000; bp[0].y = 32'h40000000;
    bp[1].a = 32'h40000000; bp[1].y = 32'h40400000;
    bp[2].a = 32'h40400000; bp[2].y = 32'h40800000;
    bp[3].a = 32'h40800000; bp[3].y = 32'h40A00000;
    bp[4].a = 32'h40A00000; bp[4].y = 32'h40C00000;
    bp[5].a = 32'h40C00000; bp[5].y = 32'h40E00000;

    bus32.in_valid = 1'b0; bus32.op = 1'b0;
    bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.op = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ov32", {31'b0, bus32.out_valid}, 32'h0);
    chk("rst_y32", bus32.y, 32'h0);
    chk("rst_f32", {28'b0, bus32.flags}, 32'h0);
    chk("rst_ov16", {31'b0, bus16.out_valid}, 32'h0);
    chk("rst_y16", {16'b0, bus16.y}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rdy32", {31'b0, bus32.in_ready}, 32'h1);
    chk("rdy16", {31'b0, bus16.in_ready}, 32'h1);

    foreach (tv[i]) send(tv[i], 1'b1);
    idle();
    drain();

    stalled = 1'b0;
    p0 = popped;
    fork
      begin
        repeat (2) @(negedge clk);
        bus32.out_ready = 1'b0;
        repeat (6) @(negedge clk);
        bus32.out_ready = 1'b1;
      end
    join_none
    foreach (bp[i]) send(bp[i], 1'b0);
    idle();
    drain();
    repeat (2) @(negedge clk);
    chk("bp_stall", {31'b0, stalled}, 32'h1);
    chk("bp_count", popped - p0, 32'd6);

    for (int i = 0; i < 3; i++) send(tv[i], 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus32.in_valid = 1'b0;
    q32.delete();
    s0 = seen;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    chk("rst_flush", seen - s0, 32'd0);

    send(tv[21], 1'b1);
    send(tv[0], 1'b1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshaking. It is the sequential successor to the combinational single-precision adder. Exponent and fraction widths are configurable, and it adds subtraction, round-to-nearest-even, special-value handling, status flags and backpressure. It sits between operand producers and result consumers in the FP datapath and accepts one operation per cycle.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline state
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands this cycle
- op  in  1  0 = a+b, 1 = a−b (sign of b inverted before alignment)
- a, b  in  W  operands {sign, exponent, fraction}, bias 2^(EXP_W−1)−1
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  W  result
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with y

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage 1 (unpack/align):
  - Flush subnormal inputs to signed zero.
  - Insert the hidden 1.
  - Swap so the operand with the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference into an extended significand with guard, round and sticky bits. Shift ≥ MAN_W+3 leaves only the sticky bit.
- Stage 2 (add): add significands when effective signs are equal, otherwise subtract smaller from larger. Result sign is the larger operand's sign.
- Stage 3 (normalise/round/pack):
  - On carry-out, shift right 1, exponent+1, OR the shifted bit into sticky.
  - Otherwise, left-shift by the leading-zero count and decrement the exponent.
  - Round to nearest, ties to even.
  - If rounding carries out, renormalise.
- Special cases, evaluated in stage 1 and carried alongside the data:
  - NaN operand, or inf − inf (effective) → y = canonical quiet NaN {0, all-ones, 1 followed by zeros}; invalid=1.
  - Single inf operand, or inf + inf with equal effective signs → that infinity; no flags.
  - Exact cancellation (including +0 − +0) → +0. Exception: (−0)+(−0) → −0.
- Overflow: rounded exponent ≥ all-ones → ±inf; overflow=1, inexact=1.
- Underflow: normalised exponent ≤ 0 → ±0; underflow=1, inexact=1.
- inexact=1 whenever guard|round|sticky ≠ 0 after normalisation.
- Results and flags leave in strict issue order.

## Timing
- Fixed latency 3 cycles: an operand accepted at edge N gives out_valid=1 after edge N+3, provided the pipeline is not stalled.
- Throughput 1/cycle.
- Stall rule: the pipeline advances when !out_valid || out_ready. in_ready equals that same advance signal, combinationally.
- Bubbles: a stage with no valid data does not stall the stages behind it.
- While out_valid=1 && out_ready=0, y and flags are held stable.
- in_valid may be asserted with in_ready=0. No transfer happens; the producer holds a, b, op.
- Reset values: out_valid=0, y=0, flags=0, all stage valid bits 0. in_ready=1 once reset deasserts.
- Reset mid-operation: in-flight operations are discarded and no out_valid pulse follows.
- No combinational path from a, b, op to y.

## Test plan
- Basic, op=0:
  - 0x3F800000+0x3F800000 → 0x40000000.
  - 0x3F000000+0x3E800000 → 0x3F400000.
  - 0x3F800000+0xBF000000 → 0x3F000000.
  - All with flags=0 and out_valid exactly 3 cycles after acceptance.
- Subtract/cancel:
  - op=1, 0x3F800000−0x3F800000 → 0x00000000, flags=0.
  - op=1, 0x41200000−0xC1200000 → 0x41A00000.
- Rounding:
  - 0x3F800000+0x33800000 (tie) → 0x3F800000, inexact=1.
  - 0x3F800000+0x33800001 → 0x3F800001, inexact=1.
- Specials:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x7F800000+0xFF800000 → 0x7FC00000, invalid=1.
  - 0x00000001+0x3F800000 → 0x3F800000, flags=0 (subnormal flushed).
- Backpressure:
  - Stream 6 back-to-back operations while out_ready=0 for cycles 2–7.
  - in_ready drops while the pipeline is full; y stays stable.
  - All 6 results emerge in order with no loss or duplication.
- Reset and parameters:
  - Assert reset with 3 operations in flight → no out_valid afterwards.
  - Rerun the basic cases with EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000.
